// File: rtl/seg_scan.sv
// seg_scan: multiplexed display scan controller feeding a hex-to-7-segment decoder.
// It holds a DIGITS-wide hex value and shows one digit per slot of PRESCALE clocks.
// New values are double-buffered: they go to a shadow register and are committed
// only on a frame boundary, so a frame is never shown half-updated.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   load       one-cycle write strobe for value/dp_mask/blank_lz
//   value      hex value; digit i = value[4i+3:4i], digit 0 is the rightmost digit
//   dp_mask    decimal point enable per digit
//   blank_lz   leading-zero blanking enable
//   nibble     code for the current digit (nibble[3] = decoder A)
//   digit_en   one-hot enable for the current digit; all-zero when blanked
//   dp         decimal point for the current digit
//   pending    a loaded value is waiting for the next frame boundary
//   frame_tick one-cycle pulse on the frame-boundary cycle
module seg_scan #(
  parameter int PRESCALE = 50000,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  dp,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = $clog2(DIGITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [SW-1:0]         slot;
  logic [4*DIGITS-1:0]   sh_value;
  logic [DIGITS-1:0]     sh_dp;
  logic                  sh_blz;
  logic [4*DIGITS-1:0]   disp_value;
  logic [DIGITS-1:0]     disp_dp;
  logic                  disp_blz;

  logic                  cnt_wrap;
  logic                  boundary;
  logic [DIGITS-1:0]     blank_vec;
  logic                  hi_zero;

  assign cnt_wrap   = (cnt == CNT_LAST);
  assign boundary   = cnt_wrap && (slot == SLOT_LAST);
  assign frame_tick = boundary;

  // Prescaler and slot counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      slot <= '0;
    end else if (cnt_wrap) begin
      cnt  <= '0;
      slot <= (slot == SLOT_LAST) ? '0 : slot + SW'(1);
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

  // Shadow / display double buffer. A load landing on the boundary cycle
  // bypasses the shadow so it is visible on the very next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_blz     <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blz   <= 1'b0;
      pending    <= 1'b0;
    end else if (load) begin
      sh_value <= value;
      sh_dp    <= dp_mask;
      sh_blz   <= blank_lz;
      if (boundary) begin
        disp_value <= value;
        disp_dp    <= dp_mask;
        disp_blz   <= blank_lz;
        pending    <= 1'b0;
      end else begin
        pending    <= 1'b1;
      end
    end else if (boundary && pending) begin
      disp_value <= sh_value;
      disp_dp    <= sh_dp;
      disp_blz   <= sh_blz;
      pending    <= 1'b0;
    end
  end

  // Digit i is blanked when it and every higher digit are zero with no decimal
  // point lit; scanning from the top keeps that as a running AND. Digit 0 is
  // never blanked.
  always_comb begin
    blank_vec = '0;
    hi_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero      = hi_zero & (disp_value[4*i +: 4] == 4'h0) & ~disp_dp[i];
      blank_vec[i] = disp_blz & hi_zero;
    end
  end

  always_comb begin
    nibble   = disp_value[{slot, 2'b00} +: 4];
    digit_en = blank_vec[slot] ? '0 : (DIGITS'(1) << slot);
    dp       = disp_dp[slot] & ~blank_vec[slot];
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed display scan controller that sits directly upstream of the hex-to-seven-segment decoder. It holds a multi-digit hex value and time-multiplexes it one digit at a time: it presents the current digit's 4-bit code to the decoder inputs and drives a one-hot digit enable plus the decimal-point bit. New values are double-buffered and committed only at frame boundaries, so the display never shows a half-updated frame. Optional leading-zero blanking suppresses unused high digits.

## Interface
- `PRESCALE`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `DIGITS`, default 4: number of multiplexed digits; must be ≥ 2.
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `load`, input, 1: single-cycle write strobe for `value`, `dp_mask` and `blank_lz`.
- `value`, input, 4*DIGITS: hex value; digit i is `value[4i+3:4i]`, and digit 0 is the rightmost digit.
- `dp_mask`, input, DIGITS: bit i lights the decimal point on digit i.
- `blank_lz`, input, 1: enables leading-zero blanking.
- `nibble`, output, 4: code for the current digit, MSB first, mapped as decoder A=`nibble[3]`, B, C, D=`nibble[0]`.
- `digit_en`, output, DIGITS: one-hot, active-high enable for the current digit; all-zero when the digit is blanked.
- `dp`, output, 1: decimal point for the current digit.
- `pending`, output, 1: a loaded value is waiting for the next frame boundary.
- `frame_tick`, output, 1: one-cycle pulse on the frame-boundary cycle.

## Operation
- **State registers:**
  - `cnt`, range 0..PRESCALE-1, width clog2(PRESCALE).
  - `slot`, range 0..DIGITS-1.
  - Shadow `{value, dp_mask, blank_lz}`.
  - Display `{value, dp_mask, blank_lz}`.
  - `pending`.
- **Prescaler:** `cnt` increments every cycle. When `cnt` reaches PRESCALE-1 it wraps to 0, and `slot` advances by 1. `slot` wraps from DIGITS-1 to 0.
- **Frame boundary:** the cycle with `cnt`==PRESCALE-1 and `slot`==DIGITS-1.
  - `frame_tick` is 1 in that cycle.
  - If `pending` is 1, the display register takes the shadow and `pending` clears.
- **Load:** `load`=1 writes the shadow and sets `pending`. Consecutive loads before a boundary overwrite the shadow; the last one wins.
- **Load on a boundary cycle:** the display register takes the incoming port values directly (bypass), the shadow is also written, and `pending` ends the cycle at 0.
- **Output derivation:** with display value V and slot s:
  - `nibble` = V[4s+3:4s].
  - `dp` = dp_mask[s].
  - `digit_en` = 1<<s, unless the digit is blanked.
- **Blanking:** digit s is blanked when all of these hold:
  - display `blank_lz`=1,
  - s>0,
  - every digit at index ≥ s is 0,
  - dp_mask has no set bit at index ≥ s.
  
  Digit 0 is never blanked. Value 0 therefore shows a single "0".
- **Blanked slots:** `digit_en`=0 and `dp`=0; `nibble` still reflects V.
- **No combinational input-to-output paths:** all outputs are functions of registered state only.

## Timing
- **Reset (asynchronous):** all registers go to 0. As a result:
  - `nibble`=0, `digit_en`=1, `dp`=0.
  - `pending`=0, `frame_tick`=0.
  - The display shows "0" on digit 0.
- **Reset mid-frame:** the current frame is abandoned. Scanning restarts at slot 0 with `cnt`=0 on the first edge after `rst` falls, and any pending load is discarded.
- **Slot length:** each slot lasts exactly PRESCALE cycles; a frame lasts DIGITS×PRESCALE cycles.
- **Commit latency:** a load is visible from the first cycle of the next slot 0. Worst case is DIGITS×PRESCALE cycles after the `load` cycle; best case is 1 cycle (load on the boundary).
- **`pending` timing:** rises the cycle after `load` and falls the cycle after the commit boundary.
- **Output changes:** `nibble`, `digit_en` and `dp` change only the cycle after a `cnt` wrap, or after a commit.

## Test plan
All scenarios use PRESCALE=4, DIGITS=4.

1. **Reset values.** Assert `rst` mid-run with `pending`=1 → outputs are immediately `nibble`=0, `digit_en`=0001, `pending`=0. After release, the slot advances every 4 cycles.
2. **Basic scan.** `load` `value`=16'h1A2F, `dp_mask`=0, `blank_lz`=0 → after the next boundary, each 4-cycle slot shows `nibble`/`digit_en` = F/0001, 2/0010, A/0100, 1/1000, repeating. `frame_tick` pulses every 16 cycles.
3. **Tear-free update.** `load` 16'h1111 mid-frame, then 16'h2222 two cycles later → the current frame finishes with the old value. `pending`=1 until the boundary, then every digit shows 2; 1 is never displayed.
4. **Boundary-cycle load.** `load` 16'hBEEF exactly on the `frame_tick` cycle → slot 0 shows F on the next cycle and `pending` stays 0.
5. **Leading-zero blanking.** `value`=16'h0030, `blank_lz`=1 → slots 3 and 2 have `digit_en`=0, slot 1 shows 3, slot 0 shows 0. With `value`=0, only slot 0 is enabled.
6. **Decimal point.** `value`=16'h0005, `blank_lz`=1, `dp_mask`=0100 → slot 2 is enabled with `dp`=1 and `nibble`=0, slot 3 is blanked, and `dp`=0 in every other slot.
